// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: pipelined inst_sram requests, in-order instruction buffer, count-based
// discard of stale responses on redirect. Optional perf counters under IF_PERF_CNT_EN.
module if_fetch_queue #(
   parameter int unsigned MAX_OUTST = 2,
   parameter int unsigned BUF_DEPTH = 4,
   parameter logic [31:0] RESET_PC  = 32'h1c000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic        inst_sram_req,
   output logic        inst_sram_wr,
   output logic [1:0]  inst_sram_size,
   output logic [3:0]  inst_sram_wstrb,
   output logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_wdata,
   input  logic        inst_sram_addr_ok,
   input  logic        inst_sram_data_ok,
   input  logic [31:0] inst_sram_rdata,
`ifdef IF_PERF_CNT_EN
   output logic [31:0] perf_discard,
   output logic [31:0] perf_stall,
`endif
   input  logic        id_allow_in,
   output logic        if_to_id_valid,
   output logic [31:0] if_to_id_pc,
   output logic [31:0] if_to_id_inst,
   output logic        if_to_id_adef
);

   localparam int unsigned OW = $clog2(MAX_OUTST) + 1;
   localparam int unsigned BW = $clog2(BUF_DEPTH) + 1;
   localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int unsigned QW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam int unsigned SW = ((OW > BW) ? OW : BW) + 1;

   logic [31:0]   pc_q, pc_d;
   logic [OW-1:0] outst_q, outst_d;
   logic [OW-1:0] discard_q, discard_d;
   logic          adef_stall_q, adef_stall_d;
   logic [BW-1:0] buf_cnt_q, buf_cnt_d;
   logic [PW-1:0] buf_rd_q, buf_rd_d, buf_wr_q, buf_wr_d;
   logic [QW-1:0] pq_rd_q, pq_rd_d, pq_wr_q, pq_wr_d;

   logic [31:0]   buf_pc   [BUF_DEPTH];
   logic [31:0]   buf_inst [BUF_DEPTH];
   logic          buf_adef [BUF_DEPTH];
   logic [31:0]   pq       [MAX_OUTST];

   logic          hs, dok, redirect, misaligned, drop, push_resp, push_adef, push, pop;
   logic [31:0]   target, push_pc, push_inst;
   logic [SW-1:0] credit_used;

   assign hs          = inst_sram_req & inst_sram_addr_ok;
   assign dok         = inst_sram_data_ok;
   assign redirect    = flush | br_taken;
   assign target      = flush ? flush_pc : br_target;
   assign misaligned  = pc_q[1:0] != 2'b00;
   assign credit_used = SW'(outst_q) + SW'(buf_cnt_q);

   // Every accepted request already owns a buffer slot, so responses can never overflow.
   assign inst_sram_req = ~reset & ~adef_stall_q & ~misaligned &
                          (outst_q < OW'(MAX_OUTST)) & (credit_used < SW'(BUF_DEPTH));
   assign inst_sram_wr    = 1'b0;
   assign inst_sram_size  = 2'b10;
   assign inst_sram_wstrb = 4'b0000;
   assign inst_sram_addr  = pc_q;
   assign inst_sram_wdata = 32'h0;

   assign drop      = dok & (redirect | (discard_q != '0));
   assign push_resp = dok & ~drop;
   assign push_adef = misaligned & ~adef_stall_q & ~redirect & (outst_q == '0) &
                      (discard_q == '0) & (buf_cnt_q != BW'(BUF_DEPTH));
   assign push      = push_resp | push_adef;
   assign pop       = if_to_id_valid & id_allow_in & ~redirect;
   assign push_pc   = push_adef ? pc_q : pq[pq_rd_q];
   assign push_inst = push_adef ? 32'h0 : inst_sram_rdata;

   assign if_to_id_valid = buf_cnt_q != '0;
   assign if_to_id_pc    = buf_pc[buf_rd_q];
   assign if_to_id_inst  = buf_inst[buf_rd_q];
   assign if_to_id_adef  = buf_adef[buf_rd_q];

   always_comb begin
      pc_d         = pc_q;
      outst_d      = outst_q + OW'(hs) - OW'(dok);
      discard_d    = discard_q;
      adef_stall_d = adef_stall_q;
      buf_cnt_d    = buf_cnt_q;
      buf_rd_d     = buf_rd_q;
      buf_wr_d     = buf_wr_q;
      pq_rd_d      = pq_rd_q;
      pq_wr_d      = pq_wr_q;

      if (hs) begin
         pc_d    = pc_q + 32'd4;
         pq_wr_d = (pq_wr_q == QW'(MAX_OUTST - 1)) ? '0 : pq_wr_q + QW'(1);
      end
      if (dok) begin
         pq_rd_d = (pq_rd_q == QW'(MAX_OUTST - 1)) ? '0 : pq_rd_q + QW'(1);
      end

      if (redirect) begin
         pc_d         = target;
         // Pending discards are a subset of outst, so every response still in flight is stale.
         discard_d    = outst_q + OW'(hs) - OW'(dok);
         adef_stall_d = 1'b0;
         buf_cnt_d    = '0;
         buf_rd_d     = '0;
         buf_wr_d     = '0;
      end else begin
         if (drop) begin
            discard_d = discard_q - OW'(1);
         end
         if (push_adef) begin
            adef_stall_d = 1'b1;
         end
         if (push) begin
            buf_wr_d = (buf_wr_q == PW'(BUF_DEPTH - 1)) ? '0 : buf_wr_q + PW'(1);
         end
         if (pop) begin
            buf_rd_d = (buf_rd_q == PW'(BUF_DEPTH - 1)) ? '0 : buf_rd_q + PW'(1);
         end
         buf_cnt_d = buf_cnt_q + BW'(push) - BW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q         <= RESET_PC;
         outst_q      <= '0;
         discard_q    <= '0;
         adef_stall_q <= 1'b0;
         buf_cnt_q    <= '0;
         buf_rd_q     <= '0;
         buf_wr_q     <= '0;
         pq_rd_q      <= '0;
         pq_wr_q      <= '0;
      end else begin
         pc_q         <= pc_d;
         outst_q      <= outst_d;
         discard_q    <= discard_d;
         adef_stall_q <= adef_stall_d;
         buf_cnt_q    <= buf_cnt_d;
         buf_rd_q     <= buf_rd_d;
         buf_wr_q     <= buf_wr_d;
         pq_rd_q      <= pq_rd_d;
         pq_wr_q      <= pq_wr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && !redirect && push) begin
         buf_pc[buf_wr_q]   <= push_pc;
         buf_inst[buf_wr_q] <= push_inst;
         buf_adef[buf_wr_q] <= push_adef;
      end
      if (!reset && hs) begin
         pq[pq_wr_q] <= pc_q;
      end
   end

`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_discard_q, perf_stall_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_discard_q <= 32'h0;
         perf_stall_q   <= 32'h0;
      end else begin
         if (drop) begin
            perf_discard_q <= perf_discard_q + 32'd1;
         end
         if (!inst_sram_req && !redirect) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
      end
   end

   assign perf_discard = perf_discard_q;
   assign perf_stall   = perf_stall_q;
`endif

`ifndef SYNTHESIS
   // A response with nothing outstanding means the bridge broke the protocol.
   assert property (@(posedge clk) disable iff (reset) inst_sram_data_ok |-> (outst_q != '0))
      else $error("if_fetch_queue: data_ok with no outstanding request");
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a simple in-order inst_sram model (1-cycle response).
module tb_if_fetch_queue;

   localparam logic [31:0] MAGIC = 32'ha5a50000;

   logic        clk, reset, flush, br_taken;
   logic [31:0] flush_pc, br_target;
   logic        req, wr;
   logic [1:0]  size;
   logic [3:0]  wstrb;
   logic [31:0] addr, wdata, rdata;
   logic        addr_ok, data_ok, id_allow_in;
   logic        if_valid, if_adef;
   logic [31:0] if_pc, if_inst;

   int          errors = 0;
   int          checks = 0;
   bit          resp_en;
   bit          saw_bt;
   logic [31:0] sq[$];

   if_fetch_queue dut (
      .clk               (clk),
      .reset             (reset),
      .flush             (flush),
      .flush_pc          (flush_pc),
      .br_taken          (br_taken),
      .br_target         (br_target),
      .inst_sram_req     (req),
      .inst_sram_wr      (wr),
      .inst_sram_size    (size),
      .inst_sram_wstrb   (wstrb),
      .inst_sram_addr    (addr),
      .inst_sram_wdata   (wdata),
      .inst_sram_addr_ok (addr_ok),
      .inst_sram_data_ok (data_ok),
      .inst_sram_rdata   (rdata),
      .id_allow_in       (id_allow_in),
      .if_to_id_valid    (if_valid),
      .if_to_id_pc       (if_pc),
      .if_to_id_inst     (if_inst),
      .if_to_id_adef     (if_adef)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One clock: capture handshake/response before the edge, then update the sram model.
   task automatic step();
      logic        hs_s, dok_s;
      logic [31:0] a_s;
      #1;
      hs_s  = req & addr_ok;
      a_s   = addr;
      dok_s = data_ok;
      @(posedge clk);
      #1;
      if (reset) begin
         sq.delete();
         data_ok = 1'b0;
         rdata   = 32'h0;
      end else begin
         if (dok_s && sq.size() > 0) void'(sq.pop_front());
         if (hs_s) begin
            sq.push_back(a_s);
            if (a_s == 32'h1c000200) saw_bt = 1'b1;
         end
         data_ok = resp_en && (sq.size() > 0);
         rdata   = data_ok ? (sq[0] ^ MAGIC) : 32'h0;
      end
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; flush = 1'b0; br_taken = 1'b0;
      addr_ok = 1'b0; resp_en = 1'b0; id_allow_in = 1'b0;
      step();
      step();
      reset = 1'b0;
      #1;
   endtask

   task automatic wait_valid(input int budget, input string name);
      int n = 0;
      while (!if_valid && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (if_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s_timeout: valid=%b after %0d cycles, want 1", name, if_valid, n);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0; br_taken = 1'b0; flush_pc = 32'h0; br_target = 32'h0;
      addr_ok = 1'b0; resp_en = 1'b0; id_allow_in = 1'b0; data_ok = 1'b0; rdata = 32'h0;
      step();
      step();
      checks++;
      if (req !== 1'b0) begin errors++; $display("FAIL reset_req_held: got %b want 0", req); end
      reset = 1'b0;
      #1;
      checks++;
      if (req !== 1'b1) begin errors++; $display("FAIL reset_req: got %b want 1", req); end
      checks++;
      if (addr !== 32'h1c000000) begin
         errors++; $display("FAIL reset_addr: got %h want 1c000000", addr);
      end
      checks++;
      if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if_valid); end
      checks++;
      if ({wr, size, wstrb, wdata} !== {1'b0, 2'b10, 4'b0, 32'h0}) begin
         errors++; $display("FAIL reset_consts: got wr=%b size=%b wstrb=%h wdata=%h",
                            wr, size, wstrb, wdata);
      end
   endtask

   task automatic test_stream();
      do_reset();
      addr_ok = 1'b1; resp_en = 1'b1; id_allow_in = 1'b1;
      step();
      checks++;
      if (addr !== 32'h1c000004 || req !== 1'b1) begin
         errors++; $display("FAIL stream_addr1: got req=%b addr=%h want 1 1c000004", req, addr);
      end
      step();
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (if_valid !== 1'b1 || if_pc !== 32'h1c000000 + 32'(4 * k) ||
             if_inst !== ((32'h1c000000 + 32'(4 * k)) ^ MAGIC)) begin
            errors++;
            $display("FAIL stream_pc%0d: got v=%b pc=%h inst=%h want pc=%h", k, if_valid, if_pc,
                     if_inst, 32'h1c000000 + 32'(4 * k));
         end
         step();
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      addr_ok = 1'b1; resp_en = 1'b1; id_allow_in = 1'b0;
      for (int k = 0; k < 4; k++) step();
      checks++;
      if (req !== 1'b0) begin errors++; $display("FAIL bp_req_drop: got %b want 0", req); end
      step();
      step();
      step();
      checks++;
      if (req !== 1'b0 || addr !== 32'h1c000010) begin
         errors++; $display("FAIL bp_hold: got req=%b addr=%h want 0 1c000010", req, addr);
      end
      id_allow_in = 1'b1;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (if_valid !== 1'b1 || if_pc !== 32'h1c000000 + 32'(4 * k)) begin
            errors++; $display("FAIL bp_pop%0d: got v=%b pc=%h want pc=%h", k, if_valid, if_pc,
                               32'h1c000000 + 32'(4 * k));
         end
         if (k == 1) begin
            checks++;
            if (req !== 1'b1 || addr !== 32'h1c000010) begin
               errors++; $display("FAIL bp_resume: got req=%b addr=%h want 1 1c000010", req, addr);
            end
         end
         step();
      end
   endtask

   task automatic test_branch_discard();
      do_reset();
      addr_ok = 1'b1; resp_en = 1'b0; id_allow_in = 1'b1;
      step();
      step();
      checks++;
      if (req !== 1'b0) begin errors++; $display("FAIL br_outst_full: got req=%b want 0", req); end
      br_taken = 1'b1; br_target = 32'h1c000100; resp_en = 1'b1;
      step();
      br_taken = 1'b0;
      checks++;
      if (addr !== 32'h1c000100 || if_valid !== 1'b0) begin
         errors++; $display("FAIL br_redirect: got addr=%h v=%b want 1c000100 0", addr, if_valid);
      end
      wait_valid(10, "br");
      checks++;
      if (if_pc !== 32'h1c000100 || if_inst !== (32'h1c000100 ^ MAGIC) || if_adef !== 1'b0) begin
         errors++; $display("FAIL br_first: got pc=%h inst=%h adef=%b want 1c000100", if_pc,
                            if_inst, if_adef);
      end
   endtask

   task automatic test_flush_priority();
      do_reset();
      saw_bt = 1'b0;
      flush = 1'b1; flush_pc = 32'h1c008000; br_taken = 1'b1; br_target = 32'h1c000200;
      step();
      flush = 1'b0; br_taken = 1'b0;
      checks++;
      if (addr !== 32'h1c008000 || req !== 1'b1) begin
         errors++; $display("FAIL flush_pc: got req=%b addr=%h want 1 1c008000", req, addr);
      end
      addr_ok = 1'b1; resp_en = 1'b1; id_allow_in = 1'b1;
      wait_valid(10, "flush");
      checks++;
      if (if_pc !== 32'h1c008000) begin
         errors++; $display("FAIL flush_first: got pc=%h want 1c008000", if_pc);
      end
      for (int k = 0; k < 4; k++) step();
      checks++;
      if (saw_bt !== 1'b0) begin
         errors++; $display("FAIL flush_no_br: got br_target requested=%b want 0", saw_bt);
      end
   endtask

   task automatic test_adef();
      do_reset();
      br_taken = 1'b1; br_target = 32'h1c000102;
      step();
      br_taken = 1'b0; addr_ok = 1'b1; resp_en = 1'b1; id_allow_in = 1'b0;
      checks++;
      if (req !== 1'b0) begin errors++; $display("FAIL adef_no_req: got %b want 0", req); end
      step();
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'h1c000102 || if_inst !== 32'h0 || if_adef !== 1'b1) begin
         errors++; $display("FAIL adef_entry: got v=%b pc=%h inst=%h adef=%b want 1 1c000102 0 1",
                            if_valid, if_pc, if_inst, if_adef);
      end
      id_allow_in = 1'b1;
      step();
      step();
      step();
      checks++;
      if (req !== 1'b0 || if_valid !== 1'b0) begin
         errors++; $display("FAIL adef_stall: got req=%b v=%b want 0 0", req, if_valid);
      end
      flush = 1'b1; flush_pc = 32'h1c008000;
      step();
      flush = 1'b0;
      checks++;
      if (req !== 1'b1 || addr !== 32'h1c008000) begin
         errors++; $display("FAIL adef_flush: got req=%b addr=%h want 1 1c008000", req, addr);
      end
      wait_valid(10, "adef");
      checks++;
      if (if_pc !== 32'h1c008000 || if_adef !== 1'b0) begin
         errors++; $display("FAIL adef_recover: got pc=%h adef=%b want 1c008000 0", if_pc, if_adef);
      end
   endtask

   task automatic test_redirect_hs_dok();
      do_reset();
      addr_ok = 1'b1; resp_en = 1'b1; id_allow_in = 1'b1;
      step();
      br_taken = 1'b1; br_target = 32'h1c000300;
      step();
      br_taken = 1'b0;
      checks++;
      if (addr !== 32'h1c000300 || if_valid !== 1'b0) begin
         errors++; $display("FAIL same_cyc_redirect: got addr=%h v=%b want 1c000300 0", addr,
                            if_valid);
      end
      wait_valid(10, "same_cyc");
      checks++;
      if (if_pc !== 32'h1c000300 || if_inst !== (32'h1c000300 ^ MAGIC)) begin
         errors++; $display("FAIL same_cyc_first: got pc=%h inst=%h want 1c000300", if_pc, if_inst);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      addr_ok = 1'b1; resp_en = 1'b1; id_allow_in = 1'b0;
      for (int k = 0; k < 3; k++) step();
      do_reset();
      checks++;
      if (if_valid !== 1'b0 || addr !== 32'h1c000000 || req !== 1'b1) begin
         errors++; $display("FAIL mid_reset: got v=%b addr=%h req=%b want 0 1c000000 1", if_valid,
                            addr, req);
      end
      addr_ok = 1'b1; resp_en = 1'b1; id_allow_in = 1'b1;
      wait_valid(10, "mid_reset");
      checks++;
      if (if_pc !== 32'h1c000000) begin
         errors++; $display("FAIL mid_reset_first: got pc=%h want 1c000000", if_pc);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_branch_discard();
      test_flush_priority();
      test_adef();
      test_redirect_hs_dok();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
